// File: rtl/phased_array_wave_gen.sv
// -----------------------------------------------------------------------------
// phased_array_wave_gen
//
// Multi-channel square-wave generator for a phased transducer array. A shared
// period counter runs over PERIOD = 2*HALF_CYC clock cycles. Each channel
// produces a 50% duty square wave delayed by its own phase offset. Phase and
// enable settings are written into shadow registers and moved into the
// active set together, only on a period boundary, so a reconfiguration never
// produces a truncated or stretched half period.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   enable       run when high; counter held at 0 and outputs low when low
//   cfg_valid    phase-write request
//   cfg_ready    high when a phase write can be accepted (no commit pending)
//   cfg_ch       target channel of the write
//   cfg_phase    phase delay in clock cycles, must be < PERIOD
//   cfg_chen     channel enable written together with the phase
//   cfg_commit   request to move the shadow set into the active set
//   cfg_err      one-cycle pulse after a rejected write
//   commit_done  one-cycle pulse when the shadow set becomes active
//   sync_out     one-cycle pulse at the start of each period
//   wave_out     per-channel square waves
// -----------------------------------------------------------------------------
module phased_array_wave_gen #(
  parameter int NUM_CH   = 8,
  parameter int HALF_CYC = 337,
  parameter int CNT_W    = 10,
  parameter int CH_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_chen,
  input  logic              cfg_commit,
  output logic              cfg_err,
  output logic              commit_done,
  output logic              sync_out,
  output logic [NUM_CH-1:0] wave_out
);

  localparam int PERIOD = 2 * HALF_CYC;
  // One spare bit so pc + PERIOD cannot overflow in the distance calculation.
  localparam int AW     = CNT_W + 1;

  localparam logic [AW-1:0]   PERIOD_W = AW'(PERIOD);
  localparam logic [AW-1:0]   HALF_W   = AW'(HALF_CYC);
  localparam logic [AW-1:0]   LAST_W   = AW'(PERIOD - 1);
  localparam logic [CH_W:0]   NUM_CH_W = (CH_W + 1)'(NUM_CH);

  // Cycles elapsed since the channel's rising edge, modulo PERIOD.
  function automatic logic [AW-1:0] phase_dist(input logic [AW-1:0] pc_v,
                                               input logic [AW-1:0] ph_v);
    logic [AW-1:0] d_v;
    if (pc_v >= ph_v) begin
      d_v = pc_v - ph_v;
    end else begin
      d_v = pc_v + PERIOD_W - ph_v;
    end
    return d_v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  pc_r;
  logic [CNT_W-1:0]  shadow_phase_r [NUM_CH];
  logic [NUM_CH-1:0] shadow_chen_r;
  logic [CNT_W-1:0]  active_phase_r [NUM_CH];
  logic [NUM_CH-1:0] active_chen_r;
  logic              pending_r;
  logic              ready_r;
  logic              idle_r;     // enable was low in the previous cycle
  logic              err_r;
  logic              done_r;
  logic              sync_r;
  logic [NUM_CH-1:0] wave_r;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  logic              wrap_s;
  logic              apply_s;
  logic              wr_s;
  logic              bad_s;
  logic              wr_ok_s;
  logic              pending_nxt_s;
  logic [NUM_CH-1:0] on_s;

  // Write acceptance, commit timing and next pending state.
  always_comb begin
    wrap_s  = 1'b0;
    apply_s = 1'b0;
    wr_s    = 1'b0;
    bad_s   = 1'b0;
    wr_ok_s = 1'b0;
    pending_nxt_s = pending_r;

    wrap_s = enable && ({1'b0, pc_r} == LAST_W);
    // While running, a commit lands on the wrap edge. Once enable has been low
    // for a full cycle (outputs already silent) it lands immediately.
    apply_s = pending_r && (wrap_s || (!enable && idle_r));
    wr_s    = cfg_valid && ready_r;
    bad_s   = ({1'b0, cfg_ch} >= NUM_CH_W) || ({1'b0, cfg_phase} >= PERIOD_W);
    wr_ok_s = wr_s && !bad_s;

    // A commit request arriving while one is pending (or being applied) is
    // absorbed by that commit.
    if (apply_s) begin
      pending_nxt_s = 1'b0;
    end else if (cfg_commit) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Per-channel wave level for the current counter value.
  always_comb begin
    on_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (active_chen_r[i]) begin
        on_s[i] = phase_dist({1'b0, pc_r}, {1'b0, active_phase_r[i]}) < HALF_W;
      end else begin
        on_s[i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // Period counter: free-running modulo PERIOD while enabled, parked at 0 otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= CNT_W'(0);
    end else if (!enable) begin
      pc_r <= CNT_W'(0);
    end else if (wrap_s) begin
      pc_r <= CNT_W'(0);
    end else begin
      pc_r <= pc_r + CNT_W'(1);
    end
  end

  // Shadow/active configuration registers and the commit handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        shadow_phase_r[i] <= CNT_W'(0);
        active_phase_r[i] <= CNT_W'(0);
      end
      shadow_chen_r <= '0;
      active_chen_r <= '0;
      pending_r     <= 1'b0;
      ready_r       <= 1'b1;
      idle_r        <= 1'b0;
      err_r         <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      // Writes cannot coincide with an apply (ready is low while pending), so
      // the active set always copies a settled shadow set.
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_ok_s && (cfg_ch == CH_W'(i))) begin
          shadow_phase_r[i] <= cfg_phase;
          shadow_chen_r[i]  <= cfg_chen;
        end
        if (apply_s) begin
          active_phase_r[i] <= shadow_phase_r[i];
          active_chen_r[i]  <= shadow_chen_r[i];
        end
      end
      pending_r <= pending_nxt_s;
      ready_r   <= !pending_nxt_s;
      idle_r    <= !enable;
      err_r     <= wr_s && bad_s;
      done_r    <= apply_s;
    end
  end

  // Registered wave and sync outputs, one cycle behind the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_r <= '0;
      sync_r <= 1'b0;
    end else if (enable) begin
      wave_r <= on_s;
      sync_r <= (pc_r == CNT_W'(0));
    end else begin
      wave_r <= '0;
      sync_r <= 1'b0;
    end
  end

  assign cfg_ready   = ready_r;
  assign cfg_err     = err_r;
  assign commit_done = done_r;
  assign sync_out    = sync_r;
  assign wave_out    = wave_r;

endmodule

// File: tb/tb_phased_array_wave_gen.sv
// Testbench for phased_array_wave_gen. A cycle reference model, written from
// the behavioural rules (modular phase distance, shadow/active copy on wrap),
// pushes the expected outputs of every clock edge into a queue; an
// independent monitor pops and compares on the falling edge.
module tb_phased_array_wave_gen;

  localparam int NUM_CH   = 8;
  localparam int HALF_CYC = 337;
  localparam int CNT_W    = 10;
  localparam int CH_W     = 5;
  localparam int PERIOD   = 2 * HALF_CYC;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic              cfg_chen = 1'b0;
  logic              cfg_commit = 1'b0;
  logic              cfg_err;
  logic              commit_done;
  logic              sync_out;
  logic [NUM_CH-1:0] wave_out;

  phased_array_wave_gen #(
    .NUM_CH(NUM_CH), .HALF_CYC(HALF_CYC), .CNT_W(CNT_W), .CH_W(CH_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_phase(cfg_phase), .cfg_chen(cfg_chen), .cfg_commit(cfg_commit),
    .cfg_err(cfg_err), .commit_done(commit_done),
    .sync_out(sync_out), .wave_out(wave_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_CH-1:0] wave;
    logic sync;
    logic err;
    logic done;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Reference model state
  int m_pc;
  int sh_ph [NUM_CH];
  bit sh_en [NUM_CH];
  int act_ph[NUM_CH];
  bit act_en[NUM_CH];
  bit m_pend;
  bit m_prev_en;

  // Reference model: predicts outputs after each rising edge.
  always @(posedge clk) begin : model
    exp_t e;
    bit   wr, bad, apply;
    if (!rst_n) begin
      m_pc = 0; m_pend = 1'b0; m_prev_en = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_ph[i] = 0; sh_en[i] = 1'b0; act_ph[i] = 0; act_en[i] = 1'b0;
      end
      e.wave = '0; e.sync = 1'b0; e.err = 1'b0; e.done = 1'b0; e.ready = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        e.wave[i] = enable && act_en[i] &&
                    (((m_pc - act_ph[i] + PERIOD) % PERIOD) < HALF_CYC);
      e.sync = enable && (m_pc == 0);
      wr     = cfg_valid && !m_pend;
      bad    = (int'(cfg_ch) >= NUM_CH) || (int'(cfg_phase) >= PERIOD);
      e.err  = wr && bad;
      apply  = m_pend && ((enable && m_pc == PERIOD - 1) || (!enable && !m_prev_en));
      e.done = apply;
      if (apply)
        for (int i = 0; i < NUM_CH; i++) begin
          act_ph[i] = sh_ph[i]; act_en[i] = sh_en[i];
        end
      if (wr && !bad) begin
        sh_ph[int'(cfg_ch)] = int'(cfg_phase);
        sh_en[int'(cfg_ch)] = cfg_chen;
      end
      m_pend    = apply ? 1'b0 : (m_pend || cfg_commit);
      e.ready   = !m_pend;
      m_pc      = enable ? (m_pc + 1) % PERIOD : 0;
      m_prev_en = enable;
    end
    exp_q.push_back(e);
  end

  // Monitor: compares DUT outputs with the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (wave_out !== e.wave || sync_out !== e.sync || cfg_err !== e.err ||
          commit_done !== e.done || cfg_ready !== e.ready) begin
        n_bad++;
        $display("FAIL outputs t=%0t got wave=%h sync=%b err=%b done=%b rdy=%b exp wave=%h sync=%b err=%b done=%b rdy=%b",
                 $time, wave_out, sync_out, cfg_err, commit_done, cfg_ready,
                 e.wave, e.sync, e.err, e.done, e.ready);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      cfg_valid = 1'b0; cfg_commit = 1'b0;
    end
  endtask

  task automatic wr(input int ch, input int ph, input bit en, input bit commit);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_phase = CNT_W'(ph);
    cfg_chen = en; cfg_commit = commit;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  // Holds a write until the DUT can accept it.
  task automatic wr_hold(input int ch, input int ph, input bit en);
    int k;
    @(negedge clk);
    cfg_valid = 1'b1; cfg_ch = CH_W'(ch); cfg_phase = CNT_W'(ph); cfg_chen = en;
    k = 0;
    while (!cfg_ready && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 2 * PERIOD) begin
      n_bad++;
      $display("FAIL wr_hold_timeout got %0d cycles required < %0d", k, 2 * PERIOD);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  task automatic wait_pc(input int target);
    int k;
    k = 0;
    while (m_pc != target && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 2 * PERIOD) begin
      n_bad++;
      $display("FAIL wait_pc_timeout got pc=%0d required %0d", m_pc, target);
    end
  endtask

  initial begin : driver
    int k, hi0, fall0, rise1, drop_cnt;

    // Reset, then run unconfigured: waves stay low, sync every PERIOD.
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1; enable = 1'b1;
    idle_cycles(2 * PERIOD + 50);

    // ch0 phase 0, ch1 phase 42; the write carrying the commit is included.
    wr(0, 0, 1'b1, 1'b0);
    wr(1, 42, 1'b1, 1'b1);
    k = 0;
    while (!commit_done && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k >= 2 * PERIOD) begin
      n_bad++;
      $display("FAIL commit_done_timeout got %0d cycles required < %0d", k, 2 * PERIOD);
    end
    k = 0;
    while (!sync_out && k < PERIOD + 2) begin
      @(negedge clk);
      k++;
    end
    hi0 = 0; fall0 = -1; rise1 = -1;
    for (int j = 0; j < PERIOD; j++) begin
      if (wave_out[0]) hi0++;
      else if (fall0 < 0) fall0 = j;
      if (wave_out[1] && rise1 < 0) rise1 = j;
      @(negedge clk);
    end
    n_vec++;
    if (hi0 != HALF_CYC) begin
      n_bad++; $display("FAIL ch0_high_count got %0d required %0d", hi0, HALF_CYC);
    end
    n_vec++;
    if (fall0 != HALF_CYC) begin
      n_bad++; $display("FAIL ch0_fall_offset got %0d required %0d", fall0, HALF_CYC);
    end
    n_vec++;
    if (rise1 != 42) begin
      n_bad++; $display("FAIL ch1_rise_offset got %0d required 42", rise1);
    end

    // Rejected writes: phase out of range and channel out of range.
    wr(2, PERIOD, 1'b1, 1'b0);
    wr(9, 5, 1'b1, 1'b0);
    idle_cycles(3);
    commit_pulse();
    idle_cycles(PERIOD + 20);

    // Write attempted during the pending window waits for commit_done.
    commit_pulse();
    wr_hold(3, 100, 1'b1);
    commit_pulse();
    idle_cycles(2 * PERIOD);

    // Randomized traffic with occasional enable drops.
    drop_cnt = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (drop_cnt > 0) begin
        enable = 1'b0; drop_cnt--;
      end else begin
        enable = 1'b1;
        if ($urandom_range(0, 1499) == 0) drop_cnt = $urandom_range(1, 5);
      end
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = CH_W'($urandom_range(0, NUM_CH + 1));
      cfg_phase = ($urandom_range(0, 7) == 0) ? CNT_W'($urandom_range(PERIOD, 1023))
                                              : CNT_W'($urandom_range(0, PERIOD - 1));
      cfg_chen  = 1'($urandom_range(0, 1));
      cfg_commit = ($urandom_range(0, 49) == 0);
    end
    idle_cycles(1);
    enable = 1'b1;
    idle_cycles(2 * PERIOD);

    // Enable dropped mid-period with a commit pending.
    wait_pc(100);
    wr(4, 300, 1'b1, 1'b1);
    wait_pc(200);
    enable = 1'b0;
    idle_cycles(3);
    enable = 1'b1;
    idle_cycles(2 * PERIOD);

    // Reset asserted at pc=500 while a commit is pending.
    wait_pc(400);
    wr(5, 17, 1'b1, 1'b1);
    wait_pc(500);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (wave_out !== '0 || sync_out !== 1'b0 || cfg_err !== 1'b0 ||
        commit_done !== 1'b0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset got wave=%h sync=%b err=%b done=%b rdy=%b required 0 0 0 0 1",
               wave_out, sync_out, cfg_err, commit_done, cfg_ready);
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    idle_cycles(2 * PERIOD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
